ac_burst_writer: RTL

AC_BURST_WRITER -- requirements
Module: ac_burst_writer

---
 rtl/ac_pkg.sv | 22 ++
 rtl/ac_sync_fifo.sv | 67 ++++++
 rtl/ac_burst_writer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ac_pkg.sv
`default_nettype none
// ==================================================================
// ac_pkg : shared FSM encoding and AXI constants for ac_burst_writer
// Rev 1.0
// ==================================================================
package ac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4,
    ST_DONE = 3'd5
  } ac_state_e;

  localparam logic [1:0]  c_burst_incr = 2'b01;
  localparam logic [1:0]  c_resp_okay  = 2'b00;
  localparam int unsigned c_4kb_bytes  = 4096;

endpackage
`default_nettype wire

// File: rtl/ac_sync_fifo.sv
`default_nettype none
// ==================================================================
// ac_sync_fifo : show-ahead synchronous FIFO with occupancy count
// Rev 1.0
// ==================================================================
module ac_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // When empty, a same-cycle push is forwarded so push+pop keeps the count.
  assign pop_data = empty ? push_data : mem_q[rd_ptr_q];

  always_comb begin
    w_do_pop  = pop && (!empty || push);
    w_do_push = push && (!full || w_do_pop);
    wr_ptr_d  = w_do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = w_do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/ac_burst_writer.sv
`default_nettype none
// ==================================================================
// ac_burst_writer : packs upsp words into AXI4 INCR write bursts
// Rev 1.0
// ==================================================================
module ac_burst_writer
  import ac_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int UPSP_DATA_WIDTH = 32,
  parameter int BURST_LEN       = 16,
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [AXI_ADDR_WIDTH-1:0]     UPSTR,
  input  logic [AXI_ADDR_WIDTH-1:0]     UPENDR,
  input  logic                          upsp_ac_wrt,
  input  logic [UPSP_DATA_WIDTH-1:0]    upsp_ac_wdata,
  output logic                          ac_upsp_wready,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awid,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          busy,
  output logic                          interrupt_updone,
  output logic                          err
);

  localparam int PACK       = AXI_DATA_WIDTH / UPSP_DATA_WIDTH;
  localparam int BEAT_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
  localparam int WORD_SHIFT = $clog2(UPSP_DATA_WIDTH / 8);
  localparam int LANE_W     = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  ac_state_e                 state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_ADDR_WIDTH-1:0] end_q, end_d;
  logic [AXI_ADDR_WIDTH-1:0] words_left_q, words_left_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [AXI_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [7:0]                awlen_q, awlen_d;
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic                      err_q, err_d;

  logic [AXI_DATA_WIDTH-1:0] w_beat;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [CNT_W-1:0]          w_fifo_count;
  logic [AXI_DATA_WIDTH-1:0] w_fifo_data;
  logic [AXI_ADDR_WIDTH-1:0] w_rem_beats;
  logic [AXI_ADDR_WIDTH-1:0] w_bnd_beats;
  logic [AXI_ADDR_WIDTH-1:0] w_n_wide;
  logic [8:0]                w_n;

  ac_sync_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_beat),
    .pop       (w_pop),
    .pop_data  (w_fifo_data),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(BEAT_SHIFT);
  assign m_axi_awburst = c_burst_incr;
  assign m_axi_awid    = 1'b0;
  assign m_axi_wdata   = w_fifo_data;
  assign m_axi_wstrb   = '1;
  assign err           = err_q;

  // Next burst length: limited by BURST_LEN, the frame remainder and the 4 KB page.
  always_comb begin
    w_rem_beats = (end_q - addr_q) >> BEAT_SHIFT;
    w_bnd_beats = (AXI_ADDR_WIDTH'(c_4kb_bytes)
                   - (addr_q & AXI_ADDR_WIDTH'(c_4kb_bytes - 1))) >> BEAT_SHIFT;
    w_n_wide    = AXI_ADDR_WIDTH'(BURST_LEN);
    if (w_rem_beats < w_n_wide) w_n_wide = w_rem_beats;
    if (w_bnd_beats < w_n_wide) w_n_wide = w_bnd_beats;
    w_n = 9'(w_n_wide);
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    end_d            = end_q;
    words_left_d     = words_left_q;
    lane_d           = lane_q;
    pack_d           = pack_q;
    awlen_d          = awlen_q;
    beat_cnt_d       = beat_cnt_q;
    err_d            = err_q;
    m_axi_awvalid    = 1'b0;
    m_axi_wvalid     = 1'b0;
    m_axi_wlast      = 1'b0;
    m_axi_bready     = 1'b0;
    interrupt_updone = 1'b0;
    w_pop            = 1'b0;

    busy           = (state_q != ST_IDLE);
    ac_upsp_wready = busy && !w_fifo_full && (words_left_q != '0);
    w_accept       = upsp_ac_wrt && ac_upsp_wready;

    w_beat = pack_q;
    for (int i = 0; i < PACK; i++) begin
      if (lane_q == LANE_W'(i)) w_beat[i*UPSP_DATA_WIDTH +: UPSP_DATA_WIDTH] = upsp_ac_wdata;
    end
    w_push = w_accept && (lane_q == LANE_W'(PACK - 1));

    if (w_accept) begin
      words_left_d = words_left_q - AXI_ADDR_WIDTH'(1);
      pack_d       = w_beat;
      lane_d       = w_push ? '0 : lane_q + LANE_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = UPSTR;
          end_d        = UPENDR;
          err_d        = 1'b0;
          lane_d       = '0;
          words_left_d = (UPENDR > UPSTR) ? (UPENDR - UPSTR) >> WORD_SHIFT : '0;
          state_d      = (UPENDR > UPSTR) ? ST_FILL : ST_DONE;
        end
      end
      ST_FILL: begin
        if (32'(w_fifo_count) >= 32'(w_n)) begin
          awlen_d    = 8'(w_n - 9'd1);
          beat_cnt_d = '0;
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = !w_fifo_empty;
        m_axi_wlast  = m_axi_wvalid && (beat_cnt_q == awlen_q);
        if (m_axi_wvalid && m_axi_wready) begin
          w_pop = 1'b1;
          if (m_axi_wlast) state_d = ST_B;
          else             beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          addr_d  = addr_q + ((AXI_ADDR_WIDTH'(awlen_q) + AXI_ADDR_WIDTH'(1)) << BEAT_SHIFT);
          err_d   = err_q | (m_axi_bresp != c_resp_okay);
          state_d = (addr_d == end_q) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        interrupt_updone = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      end_q        <= '0;
      words_left_q <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      awlen_q      <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      end_q        <= end_d;
      words_left_q <= words_left_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      awlen_q      <= awlen_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

endmodule
`default_nettype wire
